nonce_uart_tx: RTL and testbench
================================

// Module: nonce_uart_tx
// PURPOSE
// - Return path of the host serial link. Takes a winning 32-bit nonce from the processor/miner side.
// - Serializes it as a framed 8N1 UART packet on txd, back to the host that supplied the 640-bit block header.
// - Frame: SYNC byte, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0], CHK byte (6 bytes total).
// - CHK = XOR of the four nonce bytes.
// PARAMETERS
// - CLK_FREQ      100_000_000  input clock frequency in Hz
// - BAUD          115_200      line rate in bit/s
// - CLKS_PER_BIT  CLK_FREQ/BAUD  clocks per UART bit (integer division); must be >= 2
// - SYNC_BYTE     8'hA5        frame header byte
// PORTS
// - clock      in   1   system clock (100 MHz domain)
// - reset      in   1   asynchronous, active-low reset (0 = reset)
// - send       in   1   single-cycle request; nonce_in is valid in the same cycle
// - nonce_in   in   32  nonce to transmit
// - txd        out  1   UART serial output, idle high
// - busy       out  1   high while a frame is in flight
// - done       out  1   one-cycle pulse when the final stop bit completes
// - overrun    out  1   sticky; set when send arrives while busy; cleared only by reset
// BEHAVIOUR
// - Reset (asynchronous, reset=0):
//   - txd=1, busy=0, done=0, overrun=0.
//   - FSM=IDLE; all counters and the shift register are cleared.
//   - Asserting reset mid-frame aborts immediately and drives txd high. No partial-frame recovery.
// - FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (next byte: START | last byte: DONE) -> IDLE.
//   - IDLE: txd=1.
//     - On send=1: latch nonce_in into a 32-bit holding register.
//     - Compute CHK from the latched value in the same cycle.
//     - Next state LOAD. busy rises on the following edge.
//   - LOAD (1 cycle): select byte[byte_idx] into the 8-bit shift register; go to START.
//   - START: txd=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
//   - STOP: txd=1 for CLKS_PER_BIT cycles.
//     - If byte_idx<5: increment byte_idx, go to LOAD.
//     - Otherwise go to DONE.
//   - DONE (1 cycle): done=1, busy falls on the next edge. Return to IDLE.
// - Counters:
//   - baud_cnt: range 0..CLKS_PER_BIT-1; wraps to 0 on each bit boundary.
//   - bit_idx: 0..7.
//   - byte_idx: 0..5. Index 0 = SYNC, 1-4 = nonce MSB-first, 5 = CHK.
// - Timing:
//   - The start bit of byte 0 begins 2 cycles after the send cycle.
//   - Each byte occupies 10*CLKS_PER_BIT + 1 cycles (includes the LOAD cycle).
// - Handshake:
//   - send is sampled only in IDLE.
//   - send while busy (or in LOAD/DONE) is ignored, does not alter the frame in flight, and sets overrun.
//   - send coincident with done is also ignored. A new request is accepted from IDLE only.
// - The holding register is not updated by nonce_in changes after acceptance.
// STRUCTURE
// - Shared package/include (uart_pkg.vh) holds:
//   - FSM state encodings: IDLE, LOAD, START, DATA, STOP, DONE.
//   - FRAME_BYTES=6.
//   - The SYNC default.
//   - This constant set is shared with the receive-side uart_core.
// - Sub-module uart_tx_byte (byte serializer): START/DATA/STOP timing plus baud counter.
//   - Interface: load/byte in, ready/bit_done out.
// - Parent nonce_uart_tx: frame FSM, byte mux, checksum, handshake/overrun logic.
// TESTING (bench overrides CLK_FREQ=400, BAUD=100 -> CLKS_PER_BIT=4)
// 1. Reset held low, then released.
//    -> txd=1, busy=0, done=0, overrun=0. No txd edge for 100 cycles.
// 2. send=1 with nonce_in=32'h42a14695.
//    -> Decoded bytes: A5 42 A1 46 95 30.
//    -> Each byte has start=0, LSB first, stop=1. Bit width 4 cycles.
//    -> First txd falling edge 2 cycles after send.
//    -> done pulses once. busy drops the cycle after done.
// 3. send=1 with nonce_in=32'h00000000.
//    -> Bytes: A5 00 00 00 00 00.
//    -> Frame length: 6*41 cycles from LOAD to DONE.
// 4. During test 2, pulse send with nonce_in=32'hFFFFFFFF at byte 3.
//    -> Frame unchanged (A5 42 A1 46 95 30). overrun=1 and stays 1 after done.
// 5. Drive reset low mid-DATA of byte 2.
//    -> txd=1 asynchronously; busy=0, overrun=0.
//    -> A subsequent send of 32'hDEADBEEF yields a full, clean frame: A5 DE AD BE EF 22.
// 6. Back-to-back: send again the cycle after done.
//    -> Accepted (FSM in IDLE). Second frame starts 2 cycles later. overrun stays 0.

Source files
------------

// File: rtl/nonce_uart_tx_pkg.sv
// Constants and state encoding shared by the nonce return-path UART and the
// receive-side uart_core.
package nonce_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } uartState_t;

  localparam int unsigned FRAME_BYTES  = 6;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] nonceChk(input logic [31:0] nonce);
    return nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each
// held CLKS_PER_BIT clocks. txd is driven from a flop so the line never glitches.
module uart_tx_byte
  import nonce_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byteIn,
  output logic       txd,
  output logic       ready,
  output logic       bitDone
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uartState_t    state;
  uartState_t    nextState;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          baudWrap;

  assign baudWrap = (state != IDLE) && (baudCnt == BAUD_LAST);
  assign ready    = (state == IDLE);
  // bitDone marks the last clock of the stop bit, i.e. the byte is finished.
  assign bitDone  = (state == STOP) && baudWrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (load) nextState = START;
      START:   if (baudWrap) nextState = DATA;
      DATA:    if (baudWrap && bitIdx == 3'd7) nextState = STOP;
      STOP:    if (baudWrap) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txd      <= 1'b1;
    end else begin
      if (state == IDLE || baudWrap) baudCnt <= '0;
      else                           baudCnt <= baudCnt + 1'b1;

      case (state)
        IDLE: begin
          if (load) begin
            shiftReg <= byteIn;
            bitIdx   <= '0;
            txd      <= 1'b0;
          end
        end
        START: begin
          if (baudWrap) txd <= shiftReg[0];
        end
        DATA: begin
          if (baudWrap) begin
            if (bitIdx == 3'd7) begin
              txd <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 1'b1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              txd      <= shiftReg[1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nonce_uart_tx.sv
// Frames a winning nonce as SYNC, four nonce bytes MSB first, and an XOR
// checksum, and sends it to the host over the 8N1 serializer.
module nonce_uart_tx
  import nonce_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] nonce_in,
  output logic        txd,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  uartState_t  state;
  uartState_t  nextState;
  logic [31:0] nonceHold;
  logic [7:0]  chk;
  logic [2:0]  byteIdx;
  logic        overrunReg;
  logic [7:0]  byteSel;
  logic        serLoad;
  logic        serReady;
  logic        serBitDone;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // The START/DATA/STOP bit timing lives in the serializer; the frame FSM
  // stays in DATA for the whole time a byte is on the wire.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (send) nextState = LOAD;
      LOAD:    nextState = DATA;
      DATA:    if (serBitDone) nextState = (byteIdx < LAST_BYTE) ? LOAD : DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nonceHold  <= '0;
      chk        <= '0;
      byteIdx    <= '0;
      overrunReg <= 1'b0;
    end else begin
      if (state == IDLE && send) begin
        nonceHold <= nonce_in;
        chk       <= nonceChk(nonce_in);
        byteIdx   <= '0;
      end
      if (state == DATA && serBitDone && byteIdx < LAST_BYTE) byteIdx <= byteIdx + 1'b1;
      if (send && state != IDLE) overrunReg <= 1'b1;
    end
  end

  always_comb begin
    byteSel = SYNC_BYTE;
    case (byteIdx)
      3'd1:    byteSel = nonceHold[31:24];
      3'd2:    byteSel = nonceHold[23:16];
      3'd3:    byteSel = nonceHold[15:8];
      3'd4:    byteSel = nonceHold[7:0];
      3'd5:    byteSel = chk;
      default: byteSel = SYNC_BYTE;
    endcase
  end

  assign serLoad = (state == LOAD) && serReady;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign overrun = overrunReg;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock  (clock),
    .reset  (reset),
    .load   (serLoad),
    .byteIn (byteSel),
    .txd    (txd),
    .ready  (serReady),
    .bitDone(serBitDone)
  );

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Directed bench for nonce_uart_tx at 4 clocks per bit; checks the txd/busy/done
// line every cycle of each frame against a hand-derived frame timeline.
module tb_nonce_uart_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] nonce_in;
  logic        txd;
  logic        busy;
  logic        done;
  logic        overrun;

  int unsigned errors = 0;
  int unsigned checks = 0;

  nonce_uart_tx #(
    .CLK_FREQ(400),
    .BAUD    (100)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .send    (send),
    .nonce_in(nonce_in),
    .txd     (txd),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {txd, busy, done} for cycle c of a frame, c=0 being the first LOAD cycle.
  // Each byte is 41 cycles: LOAD, 4 start, 32 data (LSB first), 4 stop.
  function automatic logic [2:0] expLine(input logic [47:0] fr, input int c);
    int         k;
    int         pos;
    logic [7:0] b;
    if (c == 246) return 3'b111;
    if (c >= 247) return 3'b100;
    k   = c / 41;
    pos = c % 41;
    b   = fr[47 - 8*k -: 8];
    if (pos == 0 || pos >= 37) return 3'b110;
    if (pos <= 4) return 3'b010;
    return {b[(pos - 5) / 4], 2'b10};
  endfunction

  // Called at a negedge while the DUT is in IDLE; returns mid-LOAD of byte 0.
  task automatic doSend(input logic [31:0] n);
    send     = 1'b1;
    nonce_in = n;
    @(negedge clock);
    send     = 1'b0;
    nonce_in = ~n;
  endtask

  // pulseAt: cycle whose closing edge samples send=1 with pulseNonce (-1: none).
  task automatic checkFrame(input string tag, input logic [47:0] fr,
                            input int pulseAt, input logic [31:0] pulseNonce);
    logic [47:0] rx;
    int          k;
    int          pos;
    rx = '0;
    for (int c = 0; c < 248; c++) begin
      check($sformatf("%s line c=%0d", tag, c), 48'({txd, busy, done}), 48'(expLine(fr, c)));
      if (c < 246) begin
        k   = c / 41;
        pos = c % 41;
        if (pos >= 5 && pos <= 36 && (pos - 5) % 4 == 2) rx[40 - 8*k + (pos - 5) / 4] = txd;
      end
      send = (c == pulseAt);
      if (c == pulseAt) nonce_in = pulseNonce;
      else              nonce_in = $urandom();
      @(negedge clock);
    end
    for (int b = 0; b < 6; b++)
      check($sformatf("%s byte%0d", tag, b), 48'(rx[47 - 8*b -: 8]), 48'(fr[47 - 8*b -: 8]));
  endtask

  initial begin
    int   edges;
    logic prev;

    // 1: reset and idle line
    reset    = 1'b0;
    send     = 1'b0;
    nonce_in = '0;
    repeat (3) @(negedge clock);
    check("reset outputs", 48'({txd, busy, done, overrun}), 48'(4'b1000));
    reset = 1'b1;
    @(negedge clock);
    check("post-reset outputs", 48'({txd, busy, done, overrun}), 48'(4'b1000));
    edges = 0;
    prev  = txd;
    repeat (100) begin
      @(negedge clock);
      if (txd !== prev) edges++;
      prev = txd;
    end
    check("idle txd edges", 48'(edges), 48'd0);

    // 2 then 6/3: frame, then back-to-back send in the cycle after done
    doSend(32'h42a14695);
    checkFrame("t2", 48'hA5_42A14695_30, 247, 32'h0000_0000);
    checkFrame("t3", 48'hA5_00000000_00, -1, 32'h0);
    check("t6 overrun clear", 48'(overrun), 48'd0);

    // 4: send during byte 3 is ignored but flags overrun
    repeat (2) @(negedge clock);
    doSend(32'h42a14695);
    checkFrame("t4", 48'hA5_42A14695_30, 133, 32'hFFFF_FFFF);
    check("t4 overrun sticky", 48'(overrun), 48'd1);

    // 5: asynchronous abort in DATA of byte 2 (0x34, bit 0 low)
    repeat (2) @(negedge clock);
    doSend(32'h12345678);
    repeat (88) @(negedge clock);
    check("t5 txd before abort", 48'(txd), 48'd0);
    check("t5 overrun before abort", 48'(overrun), 48'd1);
    #2 reset = 1'b0;
    #1;
    check("t5 abort outputs", 48'({txd, busy, done, overrun}), 48'(4'b1000));
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("t5 idle after abort", 48'({txd, busy, done, overrun}), 48'(4'b1000));
    doSend(32'hDEADBEEF);
    checkFrame("t5", 48'hA5_DEADBEEF_22, -1, 32'h0);
    check("t5 overrun after frame", 48'(overrun), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
